gate_delay_sequencer: RTL and testbench
=======================================

GATE_DELAY_SEQUENCER -- requirements
Module: gate_delay_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: clock cycles STIM is held before RESP is sampled (legal range >=1).
REQ-002 The block SHALL have parameter N_STEPS, default 3: stimulus vectors applied per run (legal range >=1).
REQ-003 The block SHALL have parameter CNT_W, default 8: width of ERR_CNT.
REQ-004 The block SHALL have parameter INVERT, default 1: 1 means expected RESP = ~STIM, 0 means expected RESP = STIM.
REQ-005 The block SHALL have port CLK, input, 1 bit: single clock, rising-edge active.
REQ-006 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port START, input, 1 bit: request to begin a run, sampled in IDLE only.
REQ-008 The block SHALL have port RESP, input, 1 bit: output of the gate under test.
REQ-009 The block SHALL have port STIM, output, 1 bit: drive to the gate-under-test input.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while a run is in progress.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at run end.
REQ-012 The block SHALL have port PASS, output, 1 bit: result of the last completed run.
REQ-013 The block SHALL have port ERR_CNT, output, CNT_W bits: mismatch count for the current or last run.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETTLE and FINISH.
REQ-015 In IDLE with START=1, the block SHALL on that edge:
- go to SETTLE
- set BUSY=1
- clear ERR_CNT and PASS
- reset the step index k and the settle counter
- drive STIM = k[0] = 0
REQ-016 The stimulus for step k SHALL be k[0], giving the sequence 0,1,0,1...
REQ-017 In SETTLE, the settle counter SHALL count SETTLE_CYCLES cycles, and on the edge ending the last one the block SHALL sample RESP and compare it to the expected value.
REQ-018 On a mismatch, ERR_CNT SHALL increment by 1 and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-019 On the sampling edge, if k < N_STEPS-1, the block SHALL increment k, update STIM to the new k[0] on that same edge, restart the settle counter and remain in SETTLE.
REQ-020 On the sampling edge of step N_STEPS-1, the block SHALL:
- go to FINISH
- set STIM=0
- set PASS = (final ERR_CNT == 0), including the last comparison
REQ-021 FINISH SHALL last exactly one cycle, with DONE=1 and BUSY=0, and then return to IDLE.
REQ-022 DONE SHALL be high during FINISH only.
REQ-023 Latency from the START-accepting edge to the DONE-rising edge SHALL be N_STEPS*SETTLE_CYCLES cycles; with defaults this is 12.
REQ-024 START SHALL be ignored in SETTLE and FINISH, and a START held high SHALL re-trigger only from IDLE.
REQ-025 PASS and ERR_CNT SHALL hold their values in IDLE until the next accepted START.
REQ-026 All outputs SHALL be registered, with no combinational path from RESP or START to any output.

Reset
REQ-027 While RST_N=0, the block SHALL immediately, without waiting for a clock edge, force:
- state to IDLE
- STIM, BUSY, DONE and PASS to 0
- ERR_CNT to 0
- the step index and settle counter to 0
REQ-028 Assertion of RST_N during SETTLE or FINISH SHALL abort the run with no DONE pulse.
REQ-029 After RST_N is released, the block SHALL wait in IDLE for START.

Verification
REQ-030 Scenario, good inverter: defaults, RESP = ~STIM delayed 2 cycles, START pulsed. Required response: STIM goes 0,1,0; DONE 12 cycles after the accept edge; ERR_CNT=0; PASS=1.
REQ-031 Scenario, stuck-at-0: defaults, RESP tied to 0. Required response: steps 0 and 2 mismatch, ERR_CNT=2, PASS=0, DONE at the same latency as REQ-030.
REQ-032 Scenario, too-slow gate: defaults, RESP = ~STIM delayed 6 cycles with initial value 1. Required response: steps 1 and 2 mismatch, ERR_CNT=2, PASS=0.
REQ-033 Scenario, START held high across a run. Required response:
- exactly one DONE per run
- a new run begins on the edge after FINISH
- ERR_CNT is cleared on that edge
REQ-034 Scenario, RST_N pulsed low mid-SETTLE (step 1). Required response: all outputs are 0 asynchronously, no DONE, and a subsequent START runs cleanly to PASS=1.
REQ-035 Scenario, boundary parameters: CNT_W=1, SETTLE_CYCLES=1, N_STEPS=4, RESP=STIM with INVERT=1. Required response: ERR_CNT saturates at 1, PASS=0, DONE 4 cycles after accept.

Source files
------------

// File: rtl/gate_delay_sequencer.sv
// Gate delay sequencer: drives an alternating 0,1,0,... stimulus into a gate
// under test, lets each vector settle for SETTLE_CYCLES clocks, then samples
// the gate response. It counts mismatches against the expected (optionally
// inverted) value and reports pass/fail once per run.
module gate_delay_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned N_STEPS       = 3,
   parameter int unsigned CNT_W         = 8,
   parameter bit          INVERT        = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             resp,
   output logic             stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned K_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam int unsigned S_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [K_W-1:0]   K_LAST  = K_W'(N_STEPS - 1);
   localparam logic [S_W-1:0]   S_LAST  = S_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [K_W-1:0]   k, k_nxt;
   logic [S_W-1:0]   cnt, cnt_nxt;
   logic             stim_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [CNT_W-1:0] err_nxt;

   logic             expected_c;
   logic             mismatch_c;
   logic [CNT_W-1:0] err_inc_c;
   logic [K_W-1:0]   k_inc_c;

   // State and output registers; reset aborts any run without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         cnt     <= '0;
         stim    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= '0;
      end else begin
         state   <= state_nxt;
         k       <= k_nxt;
         cnt     <= cnt_nxt;
         stim    <= stim_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         pass    <= pass_nxt;
         err_cnt <= err_nxt;
      end
   end

   // Next-state and next-output logic for the IDLE/SETTLE/FINISH sequence.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      cnt_nxt   = cnt;
      stim_nxt  = stim;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      err_nxt   = err_cnt;

      // Expected response follows the vector currently on stim.
      expected_c = INVERT ? ~stim : stim;
      mismatch_c = (resp != expected_c);
      err_inc_c  = (mismatch_c && (err_cnt != ERR_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;
      k_inc_c    = k + K_W'(1);

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
               busy_nxt  = 1'b1;
               err_nxt   = '0;
               pass_nxt  = 1'b0;
               k_nxt     = '0;
               cnt_nxt   = '0;
               stim_nxt  = 1'b0;
            end
         end
         SETTLE: begin
            if (cnt == S_LAST) begin
               err_nxt = err_inc_c;
               cnt_nxt = '0;
               if (k == K_LAST) begin
                  state_nxt = FINISH;
                  stim_nxt  = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_inc_c == '0);
               end else begin
                  k_nxt    = k_inc_c;
                  stim_nxt = k_inc_c[0];
               end
            end else begin
               cnt_nxt = cnt + S_W'(1);
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            stim_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_gate_delay_sequencer.sv
// Bench for gate_delay_sequencer: directed scenarios plus randomized gate
// behaviours, checked against a cycle-level arithmetic model of a run.
module tb_gate_delay_sequencer;

   localparam int S  = 4;
   localparam int N  = 3;
   localparam int BS = 1;
   localparam int BN = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, resp, stim, busy, done, pass;
   logic [7:0] err_cnt;
   logic       start_b, resp_b, stim_b, busy_b, done_b, pass_b;
   logic [0:0] err_b;

   logic [1:0]  rmode;
   logic [2:0]  rdly;
   logic        bmode;
   logic [15:0] hist = '0;
   logic        dl;

   int tests = 0;
   int fails = 0;
   int last_err = 0;
   int last_pass = 0;

   always #5 clk = ~clk;

   gate_delay_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .resp(resp),
      .stim(stim), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
   );

   gate_delay_sequencer #(.SETTLE_CYCLES(BS), .N_STEPS(BN), .CNT_W(1), .INVERT(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .resp(resp_b),
      .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
   );

   // Gate-under-test models: stim history shift register feeding a delayed response.
   always @(posedge clk) hist <= {hist[14:0], stim};

   always_comb begin
      dl = (rdly == 3'd0) ? stim : hist[rdly - 3'd1];
      case (rmode)
         2'd0:    resp = ~dl;
         2'd1:    resp = 1'b0;
         2'd2:    resp = 1'b1;
         default: resp = dl;
      endcase
   end

   assign resp_b = bmode ? stim_b : ~stim_b;

   // Reference model: ideal stimulus in cycle t after the accepting edge.
   function automatic int exp_stim(int t, int n, int s);
      if (t < 0 || t >= n * s) return 0;
      return (t / s) % 2;
   endfunction

   // Gate response in cycle t for mode 0=inverter, 1=stuck0, 2=stuck1, 3=buffer.
   function automatic int exp_resp(int t, int mode, int dly, int n, int s);
      int d;
      d = exp_stim(t - dly, n, s);
      case (mode)
         0:       return 1 - d;
         1:       return 0;
         2:       return 1;
         default: return d;
      endcase
   endfunction

   // Mismatches among the first 'steps' sampled steps, saturated at maxv.
   function automatic int exp_err(int mode, int dly, int n, int s, int maxv, int steps);
      int e;
      int t;
      e = 0;
      for (int k = 0; k < steps; k++) begin
         t = (k + 1) * s - 1;
         if (exp_resp(t, mode, dly, n, s) != 1 - exp_stim(t, n, s)) e++;
      end
      if (e > maxv) e = maxv;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One run on the default instance; start accepted at the next rising edge.
   task automatic run_one(input int mode, input int dly, input bit hold, input bit rnd_start);
      int fin;
      int steps;
      fin   = exp_err(mode, dly, N, S, 255, N);
      rmode = 2'(mode);
      rdly  = 3'(dly);
      start = 1'b1;
      @(posedge clk);
      for (int t = 0; t <= N * S + 1; t++) begin
         @(negedge clk);
         steps = (t / S > N) ? N : t / S;
         check("stim", 32'(stim), 32'(exp_stim(t, N, S)));
         check("busy", 32'(busy), 32'(t < N * S));
         check("done", 32'(done), 32'(t == N * S));
         check("err_cnt", 32'(err_cnt), 32'(exp_err(mode, dly, N, S, 255, steps)));
         check("pass", 32'(pass), 32'((t >= N * S) && (fin == 0)));
         if (!hold) start = (rnd_start && t < N * S) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      last_err  = fin;
      last_pass = (fin == 0) ? 1 : 0;
   endtask

   // Idle cycles: results must hold, nothing must start or pulse.
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'(0));
         check("idle_done", 32'(done), 32'(0));
         check("idle_err", 32'(err_cnt), 32'(last_err));
         check("idle_pass", 32'(pass), 32'(last_pass));
      end
   endtask

   // One run on the boundary instance (bm=0 inverter gate, bm=1 buffer gate).
   task automatic run_b(input bit bm);
      int mode;
      int steps;
      mode    = bm ? 3 : 0;
      bmode   = bm;
      start_b = 1'b1;
      @(posedge clk);
      for (int t = 0; t <= BN * BS + 1; t++) begin
         @(negedge clk);
         start_b = 1'b0;
         steps = (t / BS > BN) ? BN : t / BS;
         check("b_stim", 32'(stim_b), 32'(exp_stim(t, BN, BS)));
         check("b_busy", 32'(busy_b), 32'(t < BN * BS));
         check("b_done", 32'(done_b), 32'(t == BN * BS));
         check("b_err", 32'(err_b), 32'(exp_err(mode, 0, BN, BS, 1, steps)));
         check("b_pass", 32'(pass_b), 32'((t >= BN * BS) && (exp_err(mode, 0, BN, BS, 1, BN) == 0)));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      start_b = 1'b0;
      rmode   = 2'd0;
      rdly    = 3'd2;
      bmode   = 1'b0;
      #12;
      check("rst_stim", 32'(stim), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_pass", 32'(pass), 32'(0));
      check("rst_err", 32'(err_cnt), 32'(0));
      check("rst_b_stim", 32'(stim_b), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);

      // Good inverter, stuck-at-0, too-slow gate.
      run_one(0, 2, 1'b0, 1'b0);
      idle(8);
      run_one(1, 0, 1'b0, 1'b0);
      idle(8);
      run_one(0, 6, 1'b0, 1'b0);
      idle(8);

      // START held high across back-to-back runs.
      run_one(1, 0, 1'b1, 1'b0);
      run_one(0, 2, 1'b1, 1'b0);
      start = 1'b0;
      idle(8);

      // Reset pulsed mid-run during step 1.
      rmode = 2'd1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_err", 32'(err_cnt), 32'(1));
      check("pre_rst_busy", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      check("arst_stim", 32'(stim), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_done", 32'(done), 32'(0));
      check("arst_pass", 32'(pass), 32'(0));
      check("arst_err", 32'(err_cnt), 32'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_done", 32'(done), 32'(0));
         check("rst_hold_busy", 32'(busy), 32'(0));
      end
      rst_n     = 1'b1;
      last_err  = 0;
      last_pass = 0;
      idle(8);
      run_one(0, 2, 1'b0, 1'b0);
      idle(8);

      // Randomized gate behaviours with START noise during runs.
      repeat (20) begin
         run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
         idle(8);
      end

      // Boundary parameters: buffer gate saturates 1-bit counter, inverter passes.
      run_b(1'b1);
      repeat (3) @(negedge clk);
      run_b(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
